// File: rtl/unidade_controle.sv
// Stack-machine control unit: fetch/decode/sequence PUSHI, DROP, NOP, ALU and HALT over an external stack datapath.
// Optional CTRL_CARRY_FLAG_EN adds a carry flag latched in EXEC and the JC (5'h18) conditional jump.
module unidade_controle (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [7:0]  pc,
  input  logic [12:0] instr,
  input  logic        empty,
  input  logic        full,
  input  logic [7:0]  s_ula,
  input  logic        carryout,
  output logic [7:0]  din,
  output logic        push,
  output logic        pop,
  output logic        load,
  output logic [4:0]  opcode,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_POP_A  = 4'd3;
  localparam logic [3:0] S_POP_B  = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_PUSH_R = 4'd6;
  localparam logic [3:0] S_DROP   = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;
  localparam logic [3:0] S_ERROR  = 4'd9;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_PUSHI = 5'h01;
  localparam logic [4:0] OP_DROP  = 5'h02;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  logic [3:0] state;
  logic [4:0] op_q;
  logic [7:0] imm_q;
  logic [7:0] result;
  logic [4:0] dec_op;
  logic [7:0] dec_imm;
  logic       is_alu;

  assign dec_op  = instr[12:8];
  assign dec_imm = instr[7:0];
  assign is_alu  = (dec_op >= 5'h08) && (dec_op <= 5'h17);

`ifdef CTRL_CARRY_FLAG_EN
  localparam logic [4:0] OP_JC = 5'h18;
  logic carry_flag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      carry_flag <= 1'b0;
    else if (state == S_EXEC)
      carry_flag <= carryout;
  end
`else
  logic unused_carry;
  assign unused_carry = carryout;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      pc     <= 8'd0;
      op_q   <= 5'd0;
      imm_q  <= 8'd0;
      result <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= 8'd0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q  <= dec_op;
          imm_q <= dec_imm;
          if (is_alu) begin
            state <= S_POP_A;
          end else begin
            case (dec_op)
              OP_NOP: begin
                pc    <= pc + 8'd1;
                state <= S_FETCH;
              end
              OP_PUSHI: state <= S_PUSH_R;
              OP_DROP:  state <= S_DROP;
              OP_HALT:  state <= S_HALT;
`ifdef CTRL_CARRY_FLAG_EN
              OP_JC: begin
                pc    <= carry_flag ? dec_imm : pc + 8'd1;
                state <= S_FETCH;
              end
`endif
              default:  state <= S_ERROR;
            endcase
          end
        end
        S_POP_A: state <= empty ? S_ERROR : S_POP_B;
        S_POP_B: state <= empty ? S_ERROR : S_EXEC;
        S_EXEC: begin
          result <= s_ula;
          state  <= S_PUSH_R;
        end
        S_PUSH_R, S_DROP: begin
          // Guard on the stack status that the current state would violate.
          if ((state == S_PUSH_R) ? full : empty) begin
            state <= S_ERROR;
          end else begin
            pc    <= pc + 8'd1;
            state <= S_FETCH;
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset clears them immediately.
  always_comb begin
    busy   = !((state == S_IDLE) || (state == S_HALT) || (state == S_ERROR));
    halted = (state == S_HALT);
    err    = (state == S_ERROR);
    push   = (state == S_PUSH_R) && !full;
    load   = ((state == S_POP_A) || (state == S_POP_B)) && !empty;
    pop    = ((state == S_POP_A) || (state == S_POP_B) || (state == S_DROP)) && !empty;
    din    = 8'd0;
    if (state == S_PUSH_R)
      din = (op_q == OP_PUSHI) ? imm_q : result;
    case (state)
      S_DECODE:                                  opcode = dec_op;
      S_POP_A, S_POP_B, S_EXEC, S_PUSH_R, S_DROP: opcode = op_q;
      default:                                   opcode = 5'd0;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: program memory, stack/adder datapath, and an instruction-level reference model.
module tb_unidade_controle;
  logic        clk = 1'b0;
  logic        rstn, start;
  logic [7:0]  pc, s_ula, din;
  logic [12:0] instr;
  logic        empty, full, carryout, push, pop, load, busy, halted, err;
  logic [4:0]  opcode;

  always #5 clk = ~clk;

  unidade_controle dut (
    .clk(clk), .rstn(rstn), .start(start), .pc(pc), .instr(instr),
    .empty(empty), .full(full), .s_ula(s_ula), .carryout(carryout),
    .din(din), .push(push), .pop(pop), .load(load), .opcode(opcode),
    .busy(busy), .halted(halted), .err(err)
  );

  // Synchronous program memory
  logic [12:0] mem [0:255];
  always @(posedge clk) instr <= mem[pc];

  // Stack datapath: depth 8, adder ALU over the two loaded operands
  logic [7:0] stk [0:15];
  logic [4:0] sp;
  logic [7:0] opa, opb;
  logic [8:0] sum;
  logic       dp_clear = 1'b1, force_full = 1'b0, force_empty = 1'b0;
  assign empty    = (sp == 5'd0) || force_empty;
  assign full     = (sp >= 5'd8) || force_full;
  assign sum      = {1'b0, opa} + {1'b0, opb};
  assign s_ula    = sum[7:0];
  assign carryout = sum[8];

  always @(posedge clk) begin
    if (dp_clear) begin
      sp <= 5'd0; opa <= 8'd0; opb <= 8'd0;
    end else if (push) begin
      stk[sp[3:0]] <= din;
      sp <= sp + 5'd1;
    end else if (pop) begin
      sp <= sp - 5'd1;
      if (load) begin
        opa <= opb;
        opb <= stk[sp[3:0] - 4'd1];
      end
    end
  end

  int n_tests = 0, n_fail = 0;
  int cyc, first_halt, first_err, clash;
  int         obs_pc[$], obs_popc[$], exp_pc[$], exp_popc[$];
  logic [7:0] obs_pv[$], exp_pv[$];
  logic [4:0] obs_po[$], exp_po[$];
  logic [4:0] p_op [0:31];
  logic [7:0] p_imm [0:31];
  int exp_halt;

  task automatic fill_mem(input logic [12:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; force_full = 1'b0; force_empty = 1'b0; dp_clear = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1; dp_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_prog();
    start = 1'b1; cyc = 0; first_halt = -1; first_err = -1; clash = 0;
    obs_pc.delete(); obs_pv.delete(); obs_po.delete(); obs_popc.delete();
  endtask

  // Cycle 1 is the FETCH of the first instruction; start is re-asserted only at cycle 'pulse'.
  task automatic observe(input int n, input int pulse);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse);
      if (push) begin obs_pc.push_back(cyc); obs_pv.push_back(din); obs_po.push_back(opcode); end
      if (pop) obs_popc.push_back(cyc);
      if (push && pop) clash++;
      if (halted && first_halt < 0) first_halt = cyc;
      if (err && first_err < 0) first_err = cyc;
    end
  endtask

  // Instruction-level model: per-op latency plus a value stack.
  task automatic model_prog(input int n);
    int c = 1;
    logic [7:0] vs[$];
    logic [7:0] a, b;
    exp_pc.delete(); exp_pv.delete(); exp_po.delete(); exp_popc.delete();
    for (int i = 0; i < n; i++) begin
      if (p_op[i] == 5'h00) c += 2;
      else if (p_op[i] == 5'h01) begin
        exp_pc.push_back(c + 2); exp_pv.push_back(p_imm[i]); exp_po.push_back(5'h01);
        vs.push_back(p_imm[i]); c += 3;
      end else if (p_op[i] == 5'h02) begin
        exp_popc.push_back(c + 2); void'(vs.pop_back()); c += 3;
      end else begin
        exp_popc.push_back(c + 2); exp_popc.push_back(c + 3);
        b = vs.pop_back(); a = vs.pop_back();
        exp_pc.push_back(c + 5); exp_pv.push_back(a + b); exp_po.push_back(p_op[i]);
        vs.push_back(a + b); c += 6;
      end
    end
    exp_halt = c + 2;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; dp_clear = 1'b1;
    #1;
    n_tests++;
    if ({pc, din, push, pop, load, opcode, busy, halted, err} !== 29'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {pc, din, push, pop, load, opcode, busy, halted, err});
    end
    do_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || pc !== 8'd0) begin
      n_fail++; $display("FAIL idle_without_start: busy=%b pc=%0d want busy=0 pc=0", busy, pc);
    end
  endtask

  task automatic test_directed_add();
    do_reset();
    fill_mem({5'h1F, 8'h00});
    mem[0] = {5'h01, 8'd3}; mem[1] = {5'h01, 8'd5}; mem[2] = {5'h08, 8'd0}; mem[3] = {5'h1F, 8'd0};
    begin_prog();
    observe(18, 5);
    n_tests++;
    if (obs_pc.size() != 3) begin
      n_fail++; $display("FAIL add_push_count: got %0d want 3", obs_pc.size());
    end else begin
      n_tests++;
      if (obs_pc[2] != 12 || obs_pv[2] !== 8'd8 || obs_po[2] !== 5'h08) begin
        n_fail++; $display("FAIL add_result_push: cyc=%0d din=%0d op=%h want cyc=12 din=8 op=08", obs_pc[2], obs_pv[2], obs_po[2]);
      end
      n_tests++;
      if (obs_pc[0] != 3 || obs_pv[0] !== 8'd3 || obs_pc[1] != 6 || obs_pv[1] !== 8'd5) begin
        n_fail++; $display("FAIL add_pushi: got %0d/%0d %0d/%0d want 3/3 6/5", obs_pc[0], obs_pv[0], obs_pc[1], obs_pv[1]);
      end
    end
    n_tests++;
    if (first_halt != 15 || halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd3) begin
      n_fail++; $display("FAIL add_halt: first=%0d halted=%b busy=%b pc=%0d want 15 1 0 3", first_halt, halted, busy, pc);
    end
    n_tests++;
    if (obs_popc.size() != 2 || clash != 0) begin
      n_fail++; $display("FAIL add_pops: pops=%0d clash=%0d want 2 0", obs_popc.size(), clash);
    end
    // Restart from HALT re-runs the program from address 0.
    begin_prog();
    observe(3, 0);
    n_tests++;
    if (halted !== 1'b0 || obs_pc.size() != 1 || obs_pv[0] !== 8'd3) begin
      n_fail++; $display("FAIL halt_restart: halted=%b pushes=%0d want 0 1", halted, obs_pc.size());
    end
  endtask

  task automatic test_random_programs();
    for (int t = 0; t < 6; t++) begin
      int n, cnt, k;
      bit bad;
      do_reset();
      fill_mem({5'h1F, 8'h00});
      n = $urandom_range(6, 20); cnt = 0;
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 3);
        p_imm[i] = 8'($urandom);
        if (k == 1 && cnt < 8) begin p_op[i] = 5'h01; cnt++; end
        else if (k == 2 && cnt >= 1) begin p_op[i] = 5'h02; p_imm[i] = 8'd0; cnt--; end
        else if (k == 3 && cnt >= 2) begin p_op[i] = 5'($urandom_range(8, 23)); cnt--; end
        else if (cnt < 2) begin p_op[i] = 5'h01; cnt++; end
        else p_op[i] = 5'h00;
        mem[i] = {p_op[i], p_imm[i]};
      end
      model_prog(n);
      begin_prog();
      observe(exp_halt + 2, 0);
      bad = (obs_pc.size() != exp_pc.size());
      for (int i = 0; i < exp_pc.size() && !bad; i++)
        if (obs_pc[i] != exp_pc[i] || obs_pv[i] !== exp_pv[i] || obs_po[i] !== exp_po[i]) bad = 1;
      n_tests++;
      if (bad) begin
        n_fail++; $display("FAIL rand_pushes[%0d]: got %0d pushes want %0d (or cycle/value/opcode differs)", t, obs_pc.size(), exp_pc.size());
      end
      n_tests++;
      if (obs_popc != exp_popc) begin
        n_fail++; $display("FAIL rand_pops[%0d]: got %0d pops want %0d (or cycles differ)", t, obs_popc.size(), exp_popc.size());
      end
      n_tests++;
      if (first_halt != exp_halt || pc !== 8'(n) || first_err != -1 || clash != 0) begin
        n_fail++; $display("FAIL rand_end[%0d]: halt=%0d pc=%0d err=%0d clash=%0d want %0d %0d -1 0", t, first_halt, pc, first_err, clash, exp_halt, n);
      end
    end
  endtask

  task automatic test_alu_empty();
    do_reset();
    fill_mem({5'h1F, 8'h00});
    mem[0] = {5'h0A, 8'h00};
    begin_prog();
    observe(8, 5);
    n_tests++;
    if (obs_popc.size() != 0 || obs_pc.size() != 0) begin
      n_fail++; $display("FAIL empty_no_pop: pops=%0d pushes=%0d want 0 0", obs_popc.size(), obs_pc.size());
    end
    n_tests++;
    if (first_err != 4 || err !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL empty_error: first=%0d err=%b busy=%b want 4 1 0", first_err, err, busy);
    end
  endtask

  task automatic test_pushi_full();
    do_reset();
    fill_mem({5'h1F, 8'h00});
    mem[0] = {5'h01, 8'h55};
    force_full = 1'b1;
    begin_prog();
    observe(8, 6);
    n_tests++;
    if (obs_pc.size() != 0 || first_err != 4 || err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_error: pushes=%0d first=%0d err=%b busy=%b want 0 4 1 0", obs_pc.size(), first_err, err, busy);
    end
    force_full = 1'b0;
  endtask

  task automatic test_nop_wrap();
    bit errseen = 0;
    do_reset();
    fill_mem(13'd0);
    begin_prog();
    for (int k = 1; k <= 515; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (err) errseen = 1;
      if (k == 3) begin
        n_tests++;
        if (pc !== 8'd1) begin n_fail++; $display("FAIL nop_incr: pc=%0d want 1", pc); end
      end
      if (k == 511) begin
        n_tests++;
        if (pc !== 8'd255) begin n_fail++; $display("FAIL nop_pc255: pc=%0d want 255", pc); end
      end
      if (k == 513) begin
        n_tests++;
        if (pc !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL nop_wrap: pc=%0d busy=%b want 0 1", pc, busy); end
      end
    end
    n_tests++;
    if (errseen) begin n_fail++; $display("FAIL nop_err: err seen=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_mem({5'h1F, 8'h00});
    mem[0] = {5'h01, 8'd1}; mem[1] = {5'h01, 8'd2}; mem[2] = {5'h09, 8'd0};
    begin_prog();
    observe(10, 0);
    n_tests++;
    if (pop !== 1'b1 || load !== 1'b1 || opcode !== 5'h09) begin
      n_fail++; $display("FAIL popb_state: pop=%b load=%b op=%h want 1 1 09", pop, load, opcode);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({pc, din, push, pop, load, opcode, busy, halted, err} !== 29'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", {pc, din, push, pop, load, opcode, busy, halted, err});
    end
    dp_clear = 1'b1;
    @(negedge clk);
    rstn = 1'b1; dp_clear = 1'b0;
    @(negedge clk);
    begin_prog();
    observe(8, 0);
    n_tests++;
    if (obs_pc.size() != 2 || obs_pc[0] != 3 || obs_pv[0] !== 8'd1 || obs_pv[1] !== 8'd2) begin
      n_fail++; $display("FAIL reset_restart: pushes=%0d want 2 (1@3, 2@6)", obs_pc.size());
    end
  endtask

  task automatic test_jc();
    do_reset();
    fill_mem({5'h1F, 8'h00});
    mem[0] = {5'h01, 8'd200}; mem[1] = {5'h01, 8'd100}; mem[2] = {5'h08, 8'd0}; mem[3] = {5'h18, 8'h40};
    begin_prog();
    observe(18, 0);
`ifdef CTRL_CARRY_FLAG_EN
    n_tests++;
    if (first_halt != 17 || pc !== 8'h40 || err !== 1'b0) begin
      n_fail++; $display("FAIL jc_taken: halt=%0d pc=%h err=%b want 17 40 0", first_halt, pc, err);
    end
    do_reset();
    mem[0] = {5'h01, 8'd1}; mem[1] = {5'h01, 8'd2};
    begin_prog();
    observe(18, 0);
    n_tests++;
    if (first_halt != 17 || pc !== 8'h04) begin
      n_fail++; $display("FAIL jc_not_taken: halt=%0d pc=%h want 17 04", first_halt, pc);
    end
`else
    n_tests++;
    if (first_err != 15 || err !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL jc_illegal: first_err=%0d err=%b want 15 1", first_err, err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed_add();
    test_random_programs();
    test_alu_empty();
    test_pushi_full();
    test_nop_wrap();
    test_reset_mid();
    test_jc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
